// File: rtl/slc3_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : slc3_exec_ctrl
// Brief    : SLC-3 execution sequencer. Debounces Run/Continue, drives the CPU
//            reset/hold/resume controls and counts retired instructions.
//            Optional macro SLC3_SINGLE_STEP_EN: step_mode parks after each
//            retired instruction.
// Revision : 1.0 - initial release
// ============================================================================
module slc3_exec_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Continue,
  input  logic             cpu_pause_req,
  input  logic             cpu_instr_done,
  input  logic             step_mode,
  output logic             cpu_rst,
  output logic             cpu_hold,
  output logic             cpu_resume,
  output logic [2:0]       exec_state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int              c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_clear  = 3'd1;
  localparam logic [2:0] c_st_run    = 3'd2;
  localparam logic [2:0] c_st_paused = 3'd3;
  localparam logic [2:0] c_st_resume = 3'd4;

  logic [1:0]       w_raw;
  logic [1:0]       w_evt;
  logic             w_run_evt;
  logic             w_cont_evt;
  logic             w_park;
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_count;

  assign w_raw = {Continue, Run};

  // Per button: sync chain, stability counter, filtered level and rise detect.
  generate
    for (genvar b = 0; b < 2; b++) begin : g_btn
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_last;
      logic [c_db_w-1:0]      r_cnt;
      logic                   r_filt;
      logic                   r_filt_d;
      logic                   w_sync;

      assign w_sync = r_sync[SYNC_STAGES-1];

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_sync   <= '0;
          r_last   <= 1'b0;
          r_cnt    <= '0;
          r_filt   <= 1'b0;
          r_filt_d <= 1'b0;
        end else begin
          r_sync   <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
          r_last   <= w_sync;
          r_filt_d <= r_filt;
          if (w_sync != r_last) begin
            r_cnt <= '0;
          end else if (r_cnt != c_db_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if ((w_sync == r_last) && (r_cnt == c_db_last)) begin
            r_filt <= w_sync;
          end
        end
      end

      assign w_evt[b] = r_filt & ~r_filt_d;
    end
  endgenerate

  assign w_run_evt  = w_evt[0];
  assign w_cont_evt = w_evt[1];

`ifdef SLC3_SINGLE_STEP_EN
  assign w_park = cpu_pause_req | (step_mode & cpu_instr_done);
`else
  logic w_step_unused;
  assign w_step_unused = step_mode;
  assign w_park        = cpu_pause_req;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Run is tested first everywhere so a simultaneous Continue is dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_run_evt) w_next = c_st_clear;
      end
      c_st_clear: begin
        w_next = c_st_run;
      end
      c_st_run: begin
        if (w_run_evt)   w_next = c_st_clear;
        else if (w_park) w_next = c_st_paused;
      end
      c_st_paused: begin
        if (w_run_evt)       w_next = c_st_clear;
        else if (w_cont_evt) w_next = c_st_resume;
      end
      c_st_resume: begin
        w_next = c_st_run;
      end
      default: begin
        w_next = c_st_idle;
      end
    endcase
  end

  always_comb begin
    cpu_rst    = (r_state == c_st_idle) || (r_state == c_st_clear);
    cpu_hold   = (r_state != c_st_run);
    cpu_resume = (r_state == c_st_resume);
    exec_state = r_state;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (r_state == c_st_clear) begin
      r_count <= '0;
    end else if ((r_state == c_st_run) && cpu_instr_done && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_slc3_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_slc3_exec_ctrl
// Brief    : Directed plus randomized bench for slc3_exec_ctrl against a
//            history-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slc3_exec_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 4;
  localparam int H    = SYNC + DEB + 1;
  localparam int MAXC = (1 << CW) - 1;

  logic          Clk      = 1'b0;
  logic          Reset_n  = 1'b0;
  logic          Run      = 1'b0;
  logic          Continue = 1'b0;
  logic          pause    = 1'b0;
  logic          done     = 1'b0;
  logic          step     = 1'b0;
  logic          cpu_rst;
  logic          cpu_hold;
  logic          cpu_resume;
  logic [2:0]    exec_state;
  logic [CW-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  slc3_exec_ctrl #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Run           (Run),
    .Continue      (Continue),
    .cpu_pause_req (pause),
    .cpu_instr_done(done),
    .step_mode     (step),
    .cpu_rst       (cpu_rst),
    .cpu_hold      (cpu_hold),
    .cpu_resume    (cpu_resume),
    .exec_state    (exec_state),
    .instr_count   (instr_count)
  );

  // Reference model: raw button history per edge, bit 0 = newest sample.
  int           m_st;
  int           m_cnt;
  logic [H-1:0] rh;
  logic [H-1:0] ch;
  logic         rf1, rf2, cf1, cf2;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Level changes once the synced samples over the window all agree.
  function automatic logic filt_next(input logic [H-1:0] h, input logic prev);
    logic [DEB:0] w;
    w = h[H-1:SYNC];
    if (&w)       return 1'b1;
    else if (~|w) return 1'b0;
    else          return prev;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; rh = '0; ch = '0;
    rf1 = 0; rf2 = 0; cf1 = 0; cf2 = 0;
  endtask

  task automatic model_step();
    logic rev, cev, park;
    rev  = rf1 & ~rf2;
    cev  = cf1 & ~cf2;
    park = pause;
`ifdef SLC3_SINGLE_STEP_EN
    park = pause | (step & done);
`endif
    case (m_st)
      0: if (rev) m_st = 1;
      1: begin m_cnt = 0; m_st = 2; end
      2: begin
        if (done && m_cnt < MAXC) m_cnt++;
        if (rev) m_st = 1;
        else if (park) m_st = 3;
      end
      3: if (rev) m_st = 1; else if (cev) m_st = 4;
      default: m_st = 2;
    endcase
    rh  = {rh[H-2:0], Run};
    ch  = {ch[H-2:0], Continue};
    rf2 = rf1; rf1 = filt_next(rh, rf1);
    cf2 = cf1; cf1 = filt_next(ch, cf1);
  endtask

  task automatic check_outputs();
    check("exec_state", exec_state, m_st);
    check("cpu_rst", cpu_rst, (m_st <= 1) ? 1 : 0);
    check("cpu_hold", cpu_hold, (m_st != 2) ? 1 : 0);
    check("cpu_resume", cpu_resume, (m_st == 4) ? 1 : 0);
    check("instr_count", instr_count, m_cnt);
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic reset_cycles(input int n);
    Reset_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge Clk);
      #1;
      check_outputs();
    end
    Reset_n = 1'b1;
  endtask

  task automatic pulse_done();
    done = 1'b1; cycle();
    done = 1'b0; cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d expected finish", $time);
    $fatal(1);
  end

  initial begin
    int bpat[6] = '{1, 1, 0, 1, 1, 0};
    int first_clear;
    int n_clear;
    int n_res;

    model_reset();
    #1;
    check_outputs();
    reset_cycles(2);
    repeat (10) cycle();
    check("idle_hold", exec_state, 0);

    // Short bounce must not register.
    foreach (bpat[i]) begin
      Run = bpat[i][0];
      cycle();
    end
    Run = 1'b0;
    repeat (12) cycle();
    check("bounce_no_evt", exec_state, 0);

    // Held press: one event, acted on 7 edges after the first high sample.
    first_clear = -1;
    n_clear     = 0;
    Run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (exec_state == 3'd1) begin
        n_clear++;
        if (first_clear < 0) first_clear = i;
      end
    end
    Run = 1'b0;
    repeat (15) begin
      cycle();
      if (exec_state == 3'd1) n_clear++;
    end
    check("run_evt_latency", first_clear, 7);
    check("clear_once", n_clear, 1);
    check("run_state", exec_state, 2);
    check("run_rst", cpu_rst, 0);

    repeat (5) pulse_done();
    pause = 1'b1; cycle();
    pause = 1'b0; cycle();
    check("count5", instr_count, 5);
    check("paused_state", exec_state, 3);
    check("paused_hold", cpu_hold, 1);

    n_res = 0;
    Continue = 1'b1;
    repeat (10) begin cycle(); n_res += int'(cpu_resume); end
    Continue = 1'b0;
    repeat (5) begin cycle(); n_res += int'(cpu_resume); end
    check("resume_once", n_res, 1);
    check("run_after_resume", exec_state, 2);

    Continue = 1'b1;
    repeat (10) cycle();
    Continue = 1'b0;
    repeat (10) cycle();
    check("cont_in_run", exec_state, 2);

    pause = 1'b1; cycle();
    pause = 1'b0; repeat (2) cycle();
    n_res = 0;
    Run = 1'b1; Continue = 1'b1;
    repeat (10) begin cycle(); n_res += int'(cpu_resume); end
    Run = 1'b0; Continue = 1'b0;
    repeat (10) begin cycle(); n_res += int'(cpu_resume); end
    check("both_no_resume", n_res, 0);
    check("both_restart", exec_state, 2);
    check("both_count0", instr_count, 0);

    repeat (20) pulse_done();
    check("saturate", instr_count, 15);

    step = 1'b1;
    Run = 1'b1; repeat (10) cycle();
    Run = 1'b0; repeat (10) cycle();
    check("step_restart", instr_count, 0);
    repeat (3) begin
      pulse_done();
      Continue = 1'b1; repeat (10) cycle();
      Continue = 1'b0; repeat (10) cycle();
    end
    check("step_count", instr_count, 3);
    pulse_done();
`ifdef SLC3_SINGLE_STEP_EN
    check("step_state", exec_state, 3);
`else
    check("step_state", exec_state, 2);
`endif
    step = 1'b0;
    Continue = 1'b1; repeat (10) cycle();
    Continue = 1'b0; repeat (10) cycle();

    repeat (3) pulse_done();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("async_state", exec_state, 0);
    check("async_rst", cpu_rst, 1);
    check("async_count", instr_count, 0);
    reset_cycles(2);
    repeat (5) cycle();

    for (int i = 0; i < 4000; i++) begin
      if (!Run) Run = ($urandom_range(0, 59) == 0);
      else      Run = ($urandom_range(0, 5) != 0);
      if (!Continue) Continue = ($urandom_range(0, 14) == 0);
      else           Continue = ($urandom_range(0, 5) != 0);
      pause = ($urandom_range(0, 24) == 0);
      done  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 199) == 0) step = ~step;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
